// File: rtl/pcie_trans_pkg.sv
// Shared definitions for the PCIe transaction path: word layout and ingress FSM encoding.
package pcie_trans_pkg;

    localparam int DATA_W   = 6;
    localparam int VC_BIT   = 5;
    localparam int DEST_BIT = 4;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSED = 2'd3
    } ingress_state_t;

endpackage

// File: rtl/pcie_ingress_ctrl_skid2.sv
// ingress_skid2: 2-entry FIFO buffer with flush; exposes occupancy and head word.
module ingress_skid2
    import pcie_trans_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(wr_en) - 2'(pop);
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pcie_ingress_ctrl.sv
// Ingress stage: valid/ready intake into a 2-entry buffer, registered push into the main FIFO.
// Optional per-VC push counters are built when PCIE_INGRESS_STATS_EN is defined.
module pcie_ingress_ctrl #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pausa_mf,
    input  logic              fifo_full_mf,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt_vc0,
    output logic [CNT_W-1:0]  cnt_vc1
);
    import pcie_trans_pkg::*;

    ingress_state_t    r_state;
    logic              r_push;
    logic [DATA_W-1:0] r_data_out;

    logic [1:0]        w_count;
    logic [DATA_W-1:0] w_head;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain;
    logic              w_stall;
    logic [1:0]        w_count_next;

    assign w_stall    = pausa_mf | fifo_full_mf;
    // Ready is a function of registered occupancy only, so a full buffer never accepts even when draining.
    assign w_in_ready = (r_state != ST_INIT) && (w_count < 2'd2);
    assign w_accept   = in_valid & w_in_ready & ~init;
    assign w_drain    = (w_count != 2'd0) & ~w_stall & (r_state != ST_INIT) & ~init;
    assign w_count_next = w_count + 2'(w_accept) - 2'(w_drain);

    ingress_skid2 #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (reset),
        .flush   (init),
        .wr_en   (w_accept),
        .wr_data (in_data),
        .pop     (w_drain),
        .count   (w_count),
        .head    (w_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_push     <= 1'b0;
            r_data_out <= '0;
        end else if (init) begin
            r_state <= ST_INIT;
            r_push  <= 1'b0;
        end else begin
            if (r_state == ST_INIT || w_count_next == 2'd0) begin
                r_state <= ST_IDLE;
            end else if (w_stall) begin
                r_state <= ST_PAUSED;
            end else begin
                r_state <= ST_ACTIVE;
            end
            r_push <= w_drain;
            if (w_drain) begin
                r_data_out <= w_head;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign push     = r_push;
    assign data_out = r_data_out;
    assign busy     = (w_count != 2'd0) | r_push;

`ifdef PCIE_INGRESS_STATS_EN
    logic [CNT_W-1:0] r_cnt_vc0;
    logic [CNT_W-1:0] r_cnt_vc1;

    // Counts pushes as they are presented to the main FIFO, keyed by the VC bit of that word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_vc0 <= '0;
            r_cnt_vc1 <= '0;
        end else if (init) begin
            r_cnt_vc0 <= '0;
            r_cnt_vc1 <= '0;
        end else if (r_push) begin
            if (r_data_out[VC_BIT]) begin
                if (r_cnt_vc1 != '1) r_cnt_vc1 <= r_cnt_vc1 + CNT_W'(1);
            end else begin
                if (r_cnt_vc0 != '1) r_cnt_vc0 <= r_cnt_vc0 + CNT_W'(1);
            end
        end
    end

    assign cnt_vc0 = r_cnt_vc0;
    assign cnt_vc1 = r_cnt_vc1;
`else
    assign cnt_vc0 = '0;
    assign cnt_vc1 = '0;
`endif

endmodule

// File: tb/tb_pcie_ingress_ctrl.sv
// Directed self-checking bench for pcie_ingress_ctrl (stats section active under PCIE_INGRESS_STATS_EN).
module tb_pcie_ingress_ctrl;

`ifdef PCIE_INGRESS_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 8;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             init;
    logic             in_valid;
    logic [5:0]       in_data;
    logic             in_ready;
    logic             pausa_mf;
    logic             fifo_full_mf;
    logic             push;
    logic [5:0]       data_out;
    logic             busy;
    logic [CNT_W-1:0] cnt_vc0;
    logic [CNT_W-1:0] cnt_vc1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pcie_ingress_ctrl #(.DATA_W(6), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .pausa_mf     (pausa_mf),
        .fifo_full_mf (fifo_full_mf),
        .push         (push),
        .data_out     (data_out),
        .busy         (busy),
        .cnt_vc0      (cnt_vc0),
        .cnt_vc1      (cnt_vc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = '0;
        pausa_mf = 1'b0; fifo_full_mf = 1'b0;
        step(); step();
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        chk("rst_push",     16'(push),     16'h0);
        chk("rst_data_out", 16'(data_out), 16'h0);
        chk("rst_busy",     16'(busy),     16'h0);
        chk("rst_cnt_vc0",  16'(cnt_vc0),  16'h0);
        chk("rst_cnt_vc1",  16'(cnt_vc1),  16'h0);
        reset = 1'b0;
        init  = 1'b1;
        step();
        chk("init_in_ready", 16'(in_ready), 16'h0);
        chk("init_push",     16'(push),     16'h0);
        step();
        chk("init_hold_in_ready", 16'(in_ready), 16'h0);
        init = 1'b0;
        step();
        chk("post_init_in_ready", 16'(in_ready), 16'h1);

        // Back-to-back stream 0x21, 0x05, 0x3F
        in_valid = 1'b1; in_data = 6'h21;
        step();
        chk("s0_push", 16'(push), 16'h0);
        chk("s0_busy", 16'(busy), 16'h1);
        in_data = 6'h05;
        step();
        chk("s1_push", 16'(push),     16'h1);
        chk("s1_data", 16'(data_out), 16'h21);
        in_data = 6'h3F;
        step();
        chk("s2_push", 16'(push),     16'h1);
        chk("s2_data", 16'(data_out), 16'h05);
        in_valid = 1'b0;
        step();
        chk("s3_push", 16'(push),     16'h1);
        chk("s3_data", 16'(data_out), 16'h3F);
        step();
        chk("s4_push", 16'(push),     16'h0);
        chk("s4_hold", 16'(data_out), 16'h3F);
        chk("s4_busy", 16'(busy),     16'h0);

        // Pause with two words queued
        pausa_mf = 1'b1; in_valid = 1'b1; in_data = 6'h0A;
        step();
        chk("p0_push",     16'(push),     16'h0);
        chk("p0_in_ready", 16'(in_ready), 16'h1);
        in_data = 6'h0B;
        step();
        chk("p1_push",     16'(push),     16'h0);
        chk("p1_in_ready", 16'(in_ready), 16'h0);
        chk("p1_busy",     16'(busy),     16'h1);
        in_data = 6'h0C;
        step();
        chk("p2_push",     16'(push),     16'h0);
        chk("p2_in_ready", 16'(in_ready), 16'h0);
        step();
        chk("p3_push", 16'(push), 16'h0);
        pausa_mf = 1'b0; in_valid = 1'b0;
        step();
        chk("p4_push",     16'(push),     16'h1);
        chk("p4_data",     16'(data_out), 16'h0A);
        chk("p4_in_ready", 16'(in_ready), 16'h1);
        step();
        chk("p5_push", 16'(push),     16'h1);
        chk("p5_data", 16'(data_out), 16'h0B);
        step();
        chk("p6_push", 16'(push), 16'h0);
        chk("p6_busy", 16'(busy), 16'h0);

        // Full flag alone blocks pushes
        fifo_full_mf = 1'b1; in_valid = 1'b1; in_data = 6'h13;
        step();
        chk("f0_push", 16'(push), 16'h0);
        in_valid = 1'b0;
        step();
        chk("f1_push", 16'(push), 16'h0);
        chk("f1_busy", 16'(busy), 16'h1);
        step();
        chk("f2_push", 16'(push), 16'h0);
        fifo_full_mf = 1'b0;
        step();
        chk("f3_push", 16'(push),     16'h1);
        chk("f3_data", 16'(data_out), 16'h13);
        step();
        chk("f4_push", 16'(push), 16'h0);

        // Pause raised while a push is in flight: that word stands, the next waits
        in_valid = 1'b1; in_data = 6'h31;
        step();
        in_data = 6'h32;
        step();
        chk("q0_push", 16'(push),     16'h1);
        chk("q0_data", 16'(data_out), 16'h31);
        pausa_mf = 1'b1; in_valid = 1'b0;
        step();
        chk("q1_push", 16'(push), 16'h0);
        chk("q1_busy", 16'(busy), 16'h1);
        pausa_mf = 1'b0;
        step();
        chk("q2_push", 16'(push),     16'h1);
        chk("q2_data", 16'(data_out), 16'h32);
        step();
        chk("q3_push", 16'(push), 16'h0);

        // Init discards buffered words
        pausa_mf = 1'b1; in_valid = 1'b1; in_data = 6'h2A;
        step();
        in_data = 6'h2B;
        step();
        chk("i0_in_ready", 16'(in_ready), 16'h0);
        in_valid = 1'b0; init = 1'b1; pausa_mf = 1'b0;
        step();
        chk("i1_push",     16'(push),     16'h0);
        chk("i1_busy",     16'(busy),     16'h0);
        chk("i1_in_ready", 16'(in_ready), 16'h0);
        init = 1'b0;
        step();
        chk("i2_push",     16'(push),     16'h0);
        chk("i2_in_ready", 16'(in_ready), 16'h1);
        in_valid = 1'b1; in_data = 6'h12;
        step();
        chk("i3_push", 16'(push), 16'h0);
        in_valid = 1'b0;
        step();
        chk("i4_push", 16'(push),     16'h1);
        chk("i4_data", 16'(data_out), 16'h12);
        step();
        chk("i5_push", 16'(push), 16'h0);

`ifdef PCIE_INGRESS_STATS_EN
        init = 1'b1;
        step();
        init = 1'b0;
        step();
        chk("st_clr_vc0", 16'(cnt_vc0), 16'h0);
        chk("st_clr_vc1", 16'(cnt_vc1), 16'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 23; i++) begin
            in_data = (i < 20) ? 6'h25 : 6'h03;
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        chk("st_vc1_sat", 16'(cnt_vc1), 16'hF);
        chk("st_vc0",     16'(cnt_vc0), 16'h3);
        init = 1'b1;
        step();
        chk("st_init_vc0", 16'(cnt_vc0), 16'h0);
        chk("st_init_vc1", 16'(cnt_vc1), 16'h0);
        init = 1'b0;
`else
        chk("nostats_vc0", 16'(cnt_vc0), 16'h0);
        chk("nostats_vc1", 16'(cnt_vc1), 16'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
